// File: rtl/imul_share_arbiter_pkg.sv
// rtl/imul_share_arbiter_pkg.sv - shared widths and FSM state encoding for the multiplier arbiter
package imul_share_arbiter_pkg;

  localparam int OP_W  = 16;
  localparam int RES_W = 32;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/IMUL_generate.sv
// rtl/IMUL_generate.sv - combinational 16x16->32 unsigned array multiplier
module IMUL_generate
  import imul_share_arbiter_pkg::*;
(
  input  logic [OP_W-1:0]  iA,
  input  logic [OP_W-1:0]  iB,
  output logic [RES_W-1:0] oP
);

  assign oP = {{(RES_W-OP_W){1'b0}}, iA} * {{(RES_W-OP_W){1'b0}}, iB};

endmodule

// File: rtl/imul_share_arbiter_rr_pick.sv
// rtl/imul_share_arbiter_rr_pick.sv - combinational round-robin pick: first request at/after pointer
module imul_share_arbiter_rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] iReq,
  input  logic [PW-1:0]   iPtr,
  output logic [NREQ-1:0] oGrant,
  output logic [PW-1:0]   oIdx,
  output logic            oAny
);

  logic [PW:0] sum;

  always_comb begin
    oGrant = '0;
    oIdx   = '0;
    oAny   = 1'b0;
    sum    = '0;
    for (int i = 0; i < NREQ; i++) begin
      sum = {1'b0, iPtr} + (PW+1)'(i);
      if (sum >= (PW+1)'(NREQ)) sum = sum - (PW+1)'(NREQ);
      if (!oAny && iReq[sum[PW-1:0]]) begin
        oAny                 = 1'b1;
        oGrant[sum[PW-1:0]]  = 1'b1;
        oIdx                 = sum[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/imul_share_arbiter.sv
// rtl/imul_share_arbiter.sv - round-robin sharing of one multiplier; IMUL_ARB_SIGNED_EN selects signed operands
module imul_share_arbiter
  import imul_share_arbiter_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int SETTLE = 2
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic [NREQ-1:0]      iReq,
  input  logic [OP_W*NREQ-1:0] iA,
  input  logic [OP_W*NREQ-1:0] iB,
  output logic [NREQ-1:0]      oGrant,
  output logic [NREQ-1:0]      oDone,
  output logic [RES_W-1:0]     oResult,
  output logic                 oBusy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  state_t             state, nextState;
  logic [PW-1:0]      ptr, curIdx, pickIdx;
  logic [NREQ-1:0]    pickGrant;
  logic               pickAny, doCapture, doFinish;
  logic [CW-1:0]      cnt;
  logic [OP_W-1:0]    rA, rB, mulA, mulB;
  logic [RES_W-1:0]   prod, result;
  logic [OP_W-1:0]    aArr [NREQ];
  logic [OP_W-1:0]    bArr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : gUnpack
    assign aArr[g] = iA[OP_W*g +: OP_W];
    assign bArr[g] = iB[OP_W*g +: OP_W];
  end

  imul_share_arbiter_rr_pick #(.NREQ(NREQ), .PW(PW)) uPick (
    .iReq   (iReq),
    .iPtr   (ptr),
    .oGrant (pickGrant),
    .oIdx   (pickIdx),
    .oAny   (pickAny)
  );

`ifdef IMUL_ARB_SIGNED_EN
  // Magnitudes go to the unsigned array; 0x8000 maps to itself, which is the correct unsigned magnitude.
  assign mulA   = rA[OP_W-1] ? (OP_W'(0) - rA) : rA;
  assign mulB   = rB[OP_W-1] ? (OP_W'(0) - rB) : rB;
  assign result = (rA[OP_W-1] ^ rB[OP_W-1]) ? (RES_W'(0) - prod) : prod;
`else
  assign mulA   = rA;
  assign mulB   = rB;
  assign result = prod;
`endif

  IMUL_generate uMul (
    .iA (mulA),
    .iB (mulB),
    .oP (prod)
  );

  always_ff @(posedge Clock) begin
    if (Reset) state <= ST_IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      ST_IDLE: if (pickAny) nextState = ST_MUL;
      ST_MUL:  if (cnt == '0) nextState = ST_IDLE;
      default: nextState = ST_IDLE;
    endcase
  end

  always_comb begin
    oBusy     = (state == ST_MUL);
    doCapture = (state == ST_IDLE) && pickAny;
    doFinish  = (state == ST_MUL) && (cnt == '0);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      ptr     <= '0;
      curIdx  <= '0;
      rA      <= '0;
      rB      <= '0;
      cnt     <= '0;
      oGrant  <= '0;
      oDone   <= '0;
      oResult <= '0;
    end else begin
      oGrant <= '0;
      oDone  <= '0;
      if (doCapture) begin
        rA     <= aArr[pickIdx];
        rB     <= bArr[pickIdx];
        curIdx <= pickIdx;
        oGrant <= pickGrant;
        cnt    <= CW'(SETTLE - 1);
      end else if (doFinish) begin
        oResult <= result;
        oDone   <= NREQ'(1) << curIdx;
        ptr     <= (curIdx == PW'(NREQ - 1)) ? '0 : curIdx + PW'(1);
      end else if (state == ST_MUL) begin
        cnt <= cnt - CW'(1);
      end
    end
  end

endmodule
